// File: rtl/flow_led_ctrl_pkg.sv
// flow_led_pkg: shared encodings for the flow LED pattern engine.
//   - MODE_*      : 2-bit run-time mode encodings presented on the mode input
//   - led_state_e : pattern FSM states
//   - is_onehot   : helper used to detect a corrupted single-hot pattern
package flow_led_pkg;

  localparam logic [1:0] MODE_ROT_L  = 2'b00;
  localparam logic [1:0] MODE_ROT_R  = 2'b01;
  localparam logic [1:0] MODE_BOUNCE = 2'b10;
  localparam logic [1:0] MODE_BLINK  = 2'b11;

  typedef enum logic [2:0] {
    ST_ROT_L,
    ST_ROT_R,
    ST_BNC_UP,
    ST_BNC_DN,
    ST_BLK_ON,
    ST_BLK_OFF
  } led_state_e;

  // Callers zero-extend their LED vector to 32 bits.
  function automatic logic is_onehot(input logic [31:0] v);
    return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/flow_led_ctrl_if.sv
// flow_led_ctrl_if: control/display bundle of one LED bank.
//   en         : 1 = run, 0 = freeze
//   mode       : pattern select (see flow_led_pkg MODE_*)
//   speed      : step period = STEP_CYCLES >> speed
//   led        : registered LED drive, 1 = on
//   step_pulse : one-cycle strobe, high when led takes a new value
// master = controller side, slave = the pattern engine.
interface flow_led_ctrl_if #(
  parameter int LED_NUM = 4
);
  logic               en;
  logic [1:0]         mode;
  logic [1:0]         speed;
  logic [LED_NUM-1:0] led;
  logic               step_pulse;

  modport master (output en, mode, speed, input led, step_pulse);
  modport slave  (input en, mode, speed, output led, step_pulse);
endinterface

// File: rtl/flow_led_ctrl_timer.sv
// led_step_timer: free-running step timer with a run-time rate shift.
//   clk, rst_n : clock, async active-low reset
//   i_en       : count enable; 0 holds the count and suppresses ticks
//   i_speed    : period = STEP_CYCLES >> i_speed
//   o_tick     : combinational, high in the last cycle of a period
module led_step_timer #(
  parameter int STEP_CYCLES = 10_000_000,
  parameter int CNT_W       = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_en,
  input  logic [1:0] i_speed,
  output logic       o_tick
);

  localparam logic [CNT_W-1:0] BASE = CNT_W'(STEP_CYCLES);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_last;

  assign w_last = (BASE >> i_speed) - CNT_W'(1);
  // >= rather than == so that lowering the period below the current count
  // fires on the next enabled cycle instead of wrapping the counter.
  assign o_tick = i_en && (r_cnt >= w_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_cnt <= '0;
    else if (o_tick) r_cnt <= '0;
    else if (i_en)   r_cnt <= r_cnt + CNT_W'(1);
  end

endmodule

// File: rtl/flow_led_ctrl.sv
// flow_led_ctrl: LED pattern engine for one bank of LED_NUM outputs.
//   sys_clk, sys_rst_n : clock, async active-low reset
//   bus (slave)        : en/mode/speed in, led/step_pulse out
// Modes: rotate-left, rotate-right, bounce, blink-all. led and step_pulse
// are registered and change one cycle after the timer tick.
module flow_led_ctrl
  import flow_led_pkg::*;
#(
  parameter int LED_NUM     = 4,
  parameter int STEP_CYCLES = 10_000_000,
  parameter int CNT_W       = 24
) (
  input  logic            sys_clk,
  input  logic            sys_rst_n,
  flow_led_ctrl_if.slave  bus
);

  localparam logic [LED_NUM-1:0] LED_LSB = LED_NUM'(1);
  localparam logic [LED_NUM-1:0] LED_MSB = {1'b1, {(LED_NUM-1){1'b0}}};
  localparam logic [LED_NUM-1:0] LED_ALL = '1;

  logic               w_tick;
  logic [LED_NUM-1:0] r_led;
  led_state_e         r_state;
  logic [1:0]         r_mode_q;
  logic               r_pulse;
  logic [LED_NUM-1:0] w_shl, w_shr, w_start_led;
  led_state_e         w_start_st;
  logic               w_onehot;

  led_step_timer #(
    .STEP_CYCLES (STEP_CYCLES),
    .CNT_W       (CNT_W)
  ) u_timer (
    .clk     (sys_clk),
    .rst_n   (sys_rst_n),
    .i_en    (bus.en),
    .i_speed (bus.speed),
    .o_tick  (w_tick)
  );

  // Pattern is one-hot in rotate/bounce, so a rotate is a valid shift.
  assign w_shl    = {r_led[LED_NUM-2:0], r_led[LED_NUM-1]};
  assign w_shr    = {r_led[0], r_led[LED_NUM-1:1]};
  assign w_onehot = is_onehot(32'(r_led));

  // Start pattern of the requested mode. Used both on a mode change and when
  // a corrupted pattern is reloaded (mode == mode_q in that case).
  always_comb begin
    w_start_led = LED_LSB;
    w_start_st  = ST_ROT_L;
    case (bus.mode)
      MODE_ROT_L:  begin w_start_led = LED_LSB; w_start_st = ST_ROT_L;  end
      MODE_ROT_R:  begin w_start_led = LED_MSB; w_start_st = ST_ROT_R;  end
      MODE_BOUNCE: begin w_start_led = LED_LSB; w_start_st = ST_BNC_UP; end
      default:     begin w_start_led = LED_ALL; w_start_st = ST_BLK_ON; end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_led    <= LED_LSB;
      r_state  <= ST_ROT_L;
      r_mode_q <= MODE_ROT_L;
      r_pulse  <= 1'b0;
    end else begin
      r_pulse <= w_tick;
      if (w_tick) begin
        if (bus.mode != r_mode_q) begin
          r_led    <= w_start_led;
          r_state  <= w_start_st;
          r_mode_q <= bus.mode;
        end else if (!w_onehot && r_state != ST_BLK_ON && r_state != ST_BLK_OFF) begin
          r_led   <= w_start_led;
          r_state <= w_start_st;
        end else begin
          case (r_state)
            ST_ROT_L: r_led <= w_shl;
            ST_ROT_R: r_led <= w_shr;
            ST_BNC_UP:
              if (r_led[LED_NUM-1]) begin r_led <= w_shr; r_state <= ST_BNC_DN; end
              else                         r_led <= w_shl;
            ST_BNC_DN:
              if (r_led[0]) begin r_led <= w_shl; r_state <= ST_BNC_UP; end
              else                 r_led <= w_shr;
            ST_BLK_ON:  begin r_led <= '0;      r_state <= ST_BLK_OFF; end
            ST_BLK_OFF: begin r_led <= LED_ALL; r_state <= ST_BLK_ON;  end
            default:    begin r_led <= w_start_led; r_state <= w_start_st; end
          endcase
        end
      end
    end
  end

  assign bus.led        = r_led;
  assign bus.step_pulse = r_pulse;

endmodule

// File: tb/tb_flow_led_ctrl.sv
// Testbench for flow_led_ctrl (LED_NUM=4, STEP_CYCLES=16).
// Stimulus pushes {expected led, expected cycle} per step into a queue; a
// negedge monitor pops on every step_pulse and otherwise checks led holds.
module tb_flow_led_ctrl;

  localparam int N  = 4;
  localparam int SC = 16;
  localparam int CW = 8;

  typedef struct {
    logic [N-1:0] led;
    int           cyc;
  } exp_t;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b1;
  always #5 sys_clk = ~sys_clk;

  flow_led_ctrl_if #(.LED_NUM(N)) bus ();

  flow_led_ctrl #(
    .LED_NUM     (N),
    .STEP_CYCLES (SC),
    .CNT_W       (CW)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  exp_t         q[$];
  exp_t         e_m;
  int           cyc      = 0;
  int           n_tests  = 0;
  int           n_fail   = 0;
  logic [N-1:0] last_led = 4'b0001;
  bit           mon_on   = 1'b0;

  always @(posedge sys_clk) cyc <= cyc + 1;

  // Monitor / scoreboard
  always @(negedge sys_clk) begin
    if (mon_on) begin
      if (!sys_rst_n) begin
        last_led = 4'b0001;
      end else if (bus.step_pulse === 1'b1) begin
        n_tests++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_step: step_pulse at cycle %0d led=%b, none expected", cyc, bus.led);
        end else begin
          e_m = q.pop_front();
          if (bus.led !== e_m.led || cyc != e_m.cyc) begin
            n_fail++;
            $display("FAIL step: got led=%b at cycle %0d, expected led=%b at cycle %0d",
                     bus.led, cyc, e_m.led, e_m.cyc);
          end
          last_led = e_m.led;
        end
      end else begin
        n_tests++;
        if (bus.led !== last_led || bus.step_pulse !== 1'b0) begin
          n_fail++;
          $display("FAIL led_hold: cycle %0d led=%b pulse=%b, expected led=%b pulse=0",
                   cyc, bus.led, bus.step_pulse, last_led);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [N-1:0] l, input int c);
    q.push_back('{led: l, cyc: c});
  endtask

  // Assert reset off the clock edges, hold 3 cycles, check reset values.
  task automatic do_reset(input string nm);
    #2 sys_rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    chk({nm, "_rst_led"},   32'(bus.led), 32'b0001);
    chk({nm, "_rst_pulse"}, 32'(bus.step_pulse), 32'd0);
  endtask

  // Release on a negedge; returns the cycle count at release.
  task automatic release_rst(output int t0);
    sys_rst_n = 1'b1;
    t0 = cyc;
  endtask

  task automatic drain(input string nm, input int budget);
    int n;
    n = 0;
    while (q.size() != 0 && n < budget) begin
      @(negedge sys_clk);
      n++;
    end
    if (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: %0d expected steps never seen", nm, q.size());
      q.delete();
    end
  endtask

  initial begin
    int t0;
    bus.en = 1'b1; bus.mode = 2'b00; bus.speed = 2'b00;
    #1 sys_rst_n = 1'b0;
    mon_on = 1'b1;
    repeat (2) @(negedge sys_clk);

    // S1: rotate-left from reset
    do_reset("s1");
    bus.en = 1'b1; bus.mode = 2'b00; bus.speed = 2'b00;
    release_rst(t0);
    push(4'b0010, t0 + 16); push(4'b0100, t0 + 32);
    push(4'b1000, t0 + 48); push(4'b0001, t0 + 64);
    drain("s1", 100);

    // S2: bounce held from reset; first tick loads the start pattern
    do_reset("s2");
    bus.en = 1'b1; bus.mode = 2'b10; bus.speed = 2'b00;
    release_rst(t0);
    push(4'b0001, t0 + 16);  push(4'b0010, t0 + 32);
    push(4'b0100, t0 + 48);  push(4'b1000, t0 + 64);
    push(4'b0100, t0 + 80);  push(4'b0010, t0 + 96);
    push(4'b0001, t0 + 112); push(4'b0010, t0 + 128);
    drain("s2", 160);

    // S3: rotate then blink mid-period
    do_reset("s3");
    bus.en = 1'b1; bus.mode = 2'b00; bus.speed = 2'b00;
    release_rst(t0);
    push(4'b0010, t0 + 16); push(4'b0100, t0 + 32);
    drain("s3a", 60);
    repeat (5) @(negedge sys_clk);
    bus.mode = 2'b11;
    push(4'b1111, t0 + 48); push(4'b0000, t0 + 64);
    push(4'b1111, t0 + 80); push(4'b0000, t0 + 96);
    drain("s3b", 80);

    // S4: speed 0 -> 3 at counter = 10
    do_reset("s4");
    bus.en = 1'b1; bus.mode = 2'b00; bus.speed = 2'b00;
    release_rst(t0);
    push(4'b0010, t0 + 11); push(4'b0100, t0 + 13);
    push(4'b1000, t0 + 15); push(4'b0001, t0 + 17);
    repeat (10) @(negedge sys_clk);
    bus.speed = 2'b11;
    drain("s4", 20);

    // S5: freeze for 40 cycles at counter = 5
    do_reset("s5");
    bus.en = 1'b1; bus.mode = 2'b00; bus.speed = 2'b00;
    release_rst(t0);
    push(4'b0010, t0 + 56); push(4'b0100, t0 + 72);
    repeat (5) @(negedge sys_clk);
    bus.en = 1'b0;
    repeat (40) @(negedge sys_clk);
    bus.en = 1'b1;
    drain("s5", 100);

    // S6: async reset while in BNC_DN showing 0100 with step_pulse high
    do_reset("s6");
    bus.en = 1'b1; bus.mode = 2'b10; bus.speed = 2'b00;
    release_rst(t0);
    push(4'b0001, t0 + 16); push(4'b0010, t0 + 32);
    push(4'b0100, t0 + 48); push(4'b1000, t0 + 64);
    push(4'b0100, t0 + 80);
    while (cyc < t0 + 80) @(negedge sys_clk);
    #2 sys_rst_n = 1'b0;
    #1;
    chk("s6_async_led",   32'(bus.led), 32'b0001);
    chk("s6_async_pulse", 32'(bus.step_pulse), 32'd0);
    chk("s6_all_steps_seen", 32'(q.size()), 32'd0);
    q.delete();
    repeat (3) @(negedge sys_clk);
    bus.mode = 2'b00;
    release_rst(t0);
    // A rotate sequence (not a bounce turn-around after 1000) shows ROT_L.
    push(4'b0010, t0 + 16); push(4'b0100, t0 + 32);
    push(4'b1000, t0 + 48); push(4'b0001, t0 + 64);
    drain("s6", 100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/flow_led_ctrl.md
Name: flow_led_ctrl

Overview:
- Parametrised LED pattern engine that drives LED_NUM outputs from a free-running step timer.
- Supports four run-time modes: rotate-left, rotate-right, bounce (ping-pong) and blink-all.
- Step rate is run-time scalable; an enable freezes the display.
- Sits directly behind the board LED pins; one instance per LED bank.

Parameters:
- LED_NUM, 4, number of LED outputs; legal range 2..32.
- STEP_CYCLES, 10_000_000, sys_clk cycles per pattern step at speed 0 (0.2 s at 50 MHz); must be >= 16.
- CNT_W, 24, tick counter width; must satisfy 2^CNT_W > STEP_CYCLES.

Ports:
- sys_clk  in  1  system clock.
- sys_rst_n  in  1  asynchronous reset, active-low.
- en  in  1  1 = run; 0 = freeze tick counter and pattern.
- mode  in  2  00 rotate-left, 01 rotate-right, 10 bounce, 11 blink-all.
- speed  in  2  step period = STEP_CYCLES >> speed (x1, x2, x4, x8 faster).
- led  out  LED_NUM  registered LED drive, 1 = on.
- step_pulse  out  1  registered one-cycle strobe, high in the cycle led takes a new value.

Behaviour:
- Reset (async assert, sync release):
  - counter = 0; led = {0..0,1}; step_pulse = 0.
  - Internal state = ROT_L; mode_q = 00.
- Tick generator:
  - limit = STEP_CYCLES >> speed.
  - When en = 1, counter increments each cycle.
  - tick = en & (counter >= limit-1); on tick, counter <= 0.
  - Using >= means a speed change that drops limit below the current count produces a tick on the next enabled cycle and never runs away.
  - en = 0: counter holds, no tick.
- Pattern update:
  - led and state change only in the cycle after tick; step_pulse mirrors the registered tick.
  - Latency from tick to new led value is 1 cycle.
- Mode sampling: mode is sampled only on tick.
  - If mode != mode_q on tick, load the start pattern of the new mode (no shift on that step) and update mode_q.
  - Start patterns: ROT_L = 0..01; ROT_R = 10..0; BOUNCE = 0..01 in state BNC_UP; BLINK = all-ones in state BLK_ON.
- States and transitions on tick with unchanged mode:
  - ROT_L: led <= {led[N-2:0], led[N-1]}.
  - ROT_R: led <= {led[0], led[N-1:1]}.
  - BNC_UP: if led[N-1] = 1, go to BNC_DN and shift right; else shift left.
  - BNC_DN: if led[0] = 1, go to BNC_UP and shift left; else shift right.
  - Bounce sequence for N = 4: 0001,0010,0100,1000,0100,0010,0001,0010,...
  - Bounce period is 2*(N-1) steps; each endpoint is shown once per pass.
  - BLK_ON: led <= 0, go to BLK_OFF.
  - BLK_OFF: led <= all-ones, go to BLK_ON.
- Invariant: in rotate and bounce states exactly one led bit is set.
  - If a fault leaves led = 0 or multi-hot, reload the mode start pattern on the next tick.
- speed changes take effect immediately on the comparison; pattern position is never altered by speed.
- en deasserted for any length: led, state and counter hold exactly; resume continues the count where it stopped.
- Reset mid-step: immediate return to reset values regardless of state.
- LED_NUM = 2: bounce degenerates to 01,10,01,10, which is legal.

Decomposition:
- Package flow_led_pkg holds:
  - mode encodings MODE_ROT_L/ROT_R/BOUNCE/BLINK (2-bit);
  - state enum ST_ROT_L, ST_ROT_R, ST_BNC_UP, ST_BNC_DN, ST_BLK_ON, ST_BLK_OFF.
- Sub-module led_step_timer (counter, limit shift, tick): reusable by other timed LED/IO blocks.
- Pattern FSM stays in flow_led_ctrl.

Test Plan:
- Config for all scenarios: STEP_CYCLES = 16, LED_NUM = 4, speed = 0.
- Reset, en = 1, mode = 00:
  - led = 0001 at reset;
  - first step_pulse at cycle 16 after release;
  - led sequence 0010,0100,1000,0001, then 16 cycles per step.
- mode = 10 held from reset:
  - first tick loads 0001 (mode change);
  - sequence 0010,0100,1000,0100,0010,0001,0010.
- mode = 00, after 2 steps (led = 0100) switch to 11 mid-period:
  - led unchanged until next tick, then 1111;
  - then alternates 0000/1111 every 16 cycles.
- speed 0 -> 3 while counter = 10:
  - tick on the next cycle (10 >= 1);
  - thereafter step_pulse every 2 cycles.
- en = 0 for 40 cycles at counter = 5:
  - no step_pulse and led constant during the freeze;
  - after en = 1, next tick occurs 11 cycles later.
- Assert sys_rst_n low asynchronously in BNC_DN with led = 0100:
  - led = 0001 and step_pulse = 0 immediately, no clock needed;
  - after release, state is ROT_L.
